// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender between a CPU byte path (req0)
// and a debug path (req1); owns the sender's level trigger and frame timeout.
module uart_tx_arbiter #(
  parameter int TRIG_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int TIMEOUT     = 200000,
  parameter int TO_W        = 18
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_trigger,
  output logic        tx_enable,
  input  logic        tx_state,
  input  logic        tx_finish,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err,
  output logic        sender_busy,
  output logic [15:0] frame_count,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte moves when reqN_valid && reqN_ready in the same cycle.
  // Ready is only offered in IDLE, to at most one requester per cycle.

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT_DONE, S_GAP} state_t;

  localparam int TC_W = $clog2(TRIG_CYCLES + 1);
  localparam int GC_W = $clog2(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT - 1);
  localparam logic [TC_W-1:0] TRIG_INI = TC_W'(TRIG_CYCLES - 1);
  localparam logic [GC_W-1:0] GAP_INI  = GC_W'(GAP_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_tx_data, w_tx_data_nxt;
  logic              r_tx_trigger, w_tx_trigger_nxt;
  logic              r_tx_enable;
  logic              r_busy;
  logic              r_grant_id, w_grant_id_nxt;
  logic              r_last_grant, w_last_grant_nxt;
  logic              r_timeout_err, w_timeout_err_nxt;
  logic              r_sender_busy;
  logic [15:0]       r_frame_count, w_frame_count_nxt;
  logic [TC_W-1:0]   r_trig_cnt, w_trig_cnt_nxt;
  logic [GC_W-1:0]   r_gap_cnt, w_gap_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt, w_to_inc;
  logic              w_idle, w_pick1, w_rdy0, w_rdy1, w_accept;

  // req1 wins when it is alone or when req0 had the previous grant.
  assign w_idle   = (r_state == S_IDLE) && reset;
  assign w_pick1  = req1_valid && (!req0_valid || !r_last_grant);
  assign w_rdy1   = w_idle && w_pick1;
  assign w_rdy0   = w_idle && req0_valid && !w_pick1;
  assign w_accept = w_rdy0 || w_rdy1;
  assign w_to_inc = (r_to_cnt == TO_MAX) ? r_to_cnt : r_to_cnt + 1'b1;

  always_comb begin
    w_state_nxt       = r_state;
    w_tx_data_nxt     = r_tx_data;
    w_tx_trigger_nxt  = r_tx_trigger;
    w_grant_id_nxt    = r_grant_id;
    w_last_grant_nxt  = r_last_grant;
    w_timeout_err_nxt = 1'b0;
    w_frame_count_nxt = r_frame_count;
    w_trig_cnt_nxt    = r_trig_cnt;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tx_data_nxt    = w_rdy1 ? req1_data : req0_data;
          w_grant_id_nxt   = w_rdy1;
          w_last_grant_nxt = w_rdy1;
          w_tx_trigger_nxt = 1'b1;
          w_trig_cnt_nxt   = TRIG_INI;
          w_to_cnt_nxt     = '0;
          w_state_nxt      = S_TRIG;
        end
      end
      S_TRIG: begin
        // A finish seen here belongs to the previous frame.
        w_to_cnt_nxt = w_to_inc;
        if (r_trig_cnt == '0) begin
          w_tx_trigger_nxt = 1'b0;
          w_state_nxt      = S_WAIT_DONE;
        end else begin
          w_trig_cnt_nxt = r_trig_cnt - 1'b1;
        end
      end
      S_WAIT_DONE: begin
        w_to_cnt_nxt = w_to_inc;
        if (tx_finish) begin
          w_frame_count_nxt = r_frame_count + 16'd1;
          w_gap_cnt_nxt     = GAP_INI;
          w_state_nxt       = S_GAP;
        end else if (r_to_cnt == TO_MAX) begin
          w_timeout_err_nxt = 1'b1;
          w_frame_count_nxt = r_frame_count + 16'd1;
          w_gap_cnt_nxt     = GAP_INI;
          w_state_nxt       = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
        else                 w_gap_cnt_nxt = r_gap_cnt - 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_tx_data     <= '0;
      r_tx_trigger  <= 1'b0;
      r_tx_enable   <= 1'b0;
      r_busy        <= 1'b0;
      r_grant_id    <= 1'b0;
      r_last_grant  <= 1'b1;
      r_timeout_err <= 1'b0;
      r_sender_busy <= 1'b0;
      r_frame_count <= '0;
      r_trig_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_to_cnt      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_trigger  <= w_tx_trigger_nxt;
      r_tx_enable   <= 1'b1;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_grant_id    <= w_grant_id_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_sender_busy <= tx_state;
      r_frame_count <= w_frame_count_nxt;
      r_trig_cnt    <= w_trig_cnt_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
    end
  end

  assign req0_ready  = w_rdy0;
  assign req1_ready  = w_rdy1;
  assign tx_data     = r_tx_data;
  assign tx_trigger  = r_tx_trigger;
  assign tx_enable   = r_tx_enable;
  assign busy        = r_busy;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;
  assign sender_busy = r_sender_busy;
  assign frame_count = r_frame_count;
  assign dbg_state   = r_state;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART sender between two byte requesters: req0 is the CPU peripheral register path, req1 is the debug/monitor path.
- Arbitrates between them round-robin and latches the winning byte.
- Generates the sender's level trigger and holds data stable for the whole frame.
- Detects frame completion via tx_finish, or via a timeout so a lost frame cannot hang the block.

Parameters:
TRIG_CYCLES, 4, sysclk cycles tx_trigger is held high per frame (>=2 so the sender's edge detector sees it)
GAP_CYCLES, 2, sysclk cycles tx_trigger is held low after a frame before the next accept (>=1)
TIMEOUT, 200000, sysclk cycles from accept to forced completion if tx_finish never arrives (>TRIG_CYCLES)
TO_W, 18, width of the timeout counter (2^TO_W > TIMEOUT)

Ports:
sysclk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous reset, active-low
req0_valid  in  1  requester 0 has a byte
req0_data  in  8  requester 0 byte
req0_ready  out  1  requester 0 byte accepted this cycle
req1_valid  in  1  requester 1 has a byte
req1_data  in  8  requester 1 byte
req1_ready  out  1  requester 1 byte accepted this cycle
tx_data  out  8  byte to sender, registered
tx_trigger  out  1  level trigger to sender; the sender starts a frame on its 0->1 transition
tx_enable  out  1  sender enable, registered
tx_state  in  1  sender busy status (observed only; exported as sender_busy)
tx_finish  in  1  sender frame-complete pulse
busy  out  1  arbiter not IDLE
grant_id  out  1  requester owning the current/last frame
timeout_err  out  1  one-cycle pulse: frame force-completed by timeout
sender_busy  out  1  registered copy of tx_state
frame_count  out  16  frames completed (finish or timeout), wraps 0xFFFF->0

Behaviour:
- Reset (reset==0 at a sysclk edge), all cleared:
  - state=IDLE; tx_data=0, tx_trigger=0, tx_enable=0, busy=0, grant_id=0, timeout_err=0, sender_busy=0, frame_count=0.
  - last_grant=1, so req0 wins the first tie.
- tx_enable is 1 from the first edge after reset deasserts.
- Reset mid-frame: trigger drops the next edge; the in-flight byte is neither acked again nor retried.
- States: IDLE, TRIG, WAIT_DONE, GAP.
- Readiness and grant:
  - reqN_ready is combinational and only in IDLE; at most one ready per cycle.
  - One valid requester: it gets ready.
  - Both valid: the requester != last_grant gets ready.
  - Handshake = valid && ready in the same cycle.
- IDLE, on accept (next edge):
  - tx_data<=winner data; grant_id, last_grant<=winner; tx_trigger<=1.
  - trig_cnt<=TRIG_CYCLES-1; to_cnt<=0; go TRIG.
  - Accept to tx_trigger high: 1 cycle.
- TRIG:
  - tx_trigger stays 1 for exactly TRIG_CYCLES cycles, then <=0 and go WAIT_DONE.
  - tx_finish is ignored here (stale from a prior frame).
  - to_cnt increments.
- WAIT_DONE:
  - to_cnt increments each cycle.
  - tx_finish==1: go GAP, frame_count++.
  - Else if to_cnt==TIMEOUT-1: timeout_err<=1 for one cycle, frame_count++, go GAP.
  - Finish and timeout in the same cycle count as finish; no error pulse.
- GAP:
  - tx_trigger=0 for GAP_CYCLES cycles, then IDLE.
  - No ready is asserted during GAP.
- tx_data is held constant from accept until the next accept, because the sender samples bits throughout the frame.
- busy=(state!=IDLE), registered with the state.
- sender_busy<=tx_state each cycle; it does not affect sequencing.
- Valids that drop before ready are simply not served; no data is buffered beyond tx_data.
- Counter width: to_cnt is TO_W bits and saturates at TIMEOUT-1. frame_count wraps modulo 2^16.

Test Plan:
- Reset, then req0_valid=1, data=0x41: req0_ready=1 in the same cycle; next edge tx_data=0x41, tx_trigger=1 for 4 cycles, then 0.
- Pulse tx_finish 50 cycles after accept: WAIT_DONE->GAP; frame_count=1; 2 idle cycles; then ready possible again; timeout_err stays 0.
- req0 and req1 both held valid with 0x11/0x22:
  - grants alternate 0,1,0,1 (first grant req0).
  - tx_data sequence 0x11,0x22,0x11,0x22 with finish pulsed each frame.
- Never pulse tx_finish with TIMEOUT=100: timeout_err one-cycle pulse exactly 100 cycles after accept; frame_count increments; return to IDLE after GAP.
- tx_finish asserted during TRIG: ignored; block stays until a finish in WAIT_DONE.
- reset=0 while in WAIT_DONE with trigger low: next edge all outputs 0, state IDLE; a pending req1 is accepted on the first IDLE cycle after release.
